// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// UART_PARITY_EN adds an even-parity bit and moves the STATUS count field up one bit.
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;
`ifdef UART_PARITY_EN
  localparam int ST_CNT   = 5;
`else
  localparam int ST_CNT   = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // a simultaneous pop frees the slot the push lands in
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO plus 8N1 serialiser on the core bus.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  input  logic        rw,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e       state, state_nx;
  logic [15:0]     div;
  logic [15:0]     baud, baud_nx;
  logic [2:0]      bit_cnt, bit_nx;
  logic [7:0]      shift, shift_nx;
  logic            ovf;
  logic            sel, wr, tick;
  logic [3:0]      off;
  logic            fifo_push, fifo_pop;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_cnt;
  logic [31:0]     status, rdata;
  logic            unused_hi;
`ifdef UART_PARITY_EN
  logic            par, par_nx;
`endif

  assign off       = addr[3:0];
  assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (size != SZ_RSVD);
  assign wr        = sel && rw;
  assign fifo_push = wr && (off == OFF_TXDATA);
  assign tick      = (baud == 16'd0);
  assign irq       = fifo_empty && (state == S_IDLE);
  assign unused_hi = ^data[31:16];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop)
        ovf <= 1'b1;
      else if (wr && off == OFF_STATUS && size == SZ_WORD && data[ST_OVF])
        ovf <= 1'b0;
      if (wr && off == OFF_DIVISOR && size == SZ_WORD)
        div <= data[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_cnt <= bit_nx;
      shift   <= shift_nx;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else      par <= par_nx;
  end
`endif

  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    fifo_pop = 1'b0;
    tx       = 1'b1;
`ifdef UART_PARITY_EN
    par_nx   = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_nx = fifo_dout;
          baud_nx  = div;
          bit_nx   = 3'd0;
          state_nx = S_START;
`ifdef UART_PARITY_EN
          par_nx   = ^fifo_dout;
`endif
        end
      end
      S_START: begin
        tx = 1'b0;
        if (tick) state_nx = S_DATA;
      end
      S_DATA: begin
        tx = shift[0];
        if (tick) begin
          shift_nx = {1'b0, shift[7:1]};
          bit_nx   = bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_cnt == 3'd7) state_nx = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_nx = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx = par;
        if (tick) state_nx = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // bit boundaries reload from the live divisor
    if (state != S_IDLE)
      baud_nx = tick ? div : baud - 16'd1;
  end

  always_comb begin
    status = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state != S_IDLE);
    status[ST_OVF]   = ovf;
    status[ST_CNT +: CW] = fifo_cnt;
`ifdef UART_PARITY_EN
    status[ST_PAR]   = 1'b1;
`endif
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == OFF_STATUS:  rdata = status;
      off == OFF_DIVISOR: rdata = {16'b0, div};
      default: ;
    endcase
  end

  assign data = (sel && !rw) ? rdata : 'z;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vectors, frame timing,
// overflow, divisor change, async reset and randomized bursts.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'hFFFF0000;
  localparam logic [31:0] A_TX    = BASE + 32'h0;
  localparam logic [31:0] A_ST    = BASE + 32'h4;
  localparam logic [31:0] A_DIV   = BASE + 32'h8;
  localparam logic [31:0] ISO_PAT = 32'hA5A5A5A0;
  localparam logic [1:0]  BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr;
  logic        rw;
  logic [1:0]  size;
  logic        tx, irq;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] data;

  int n_chk = 0;
  int n_pass = 0;

  assign data = drv_en ? drv_val : 32'bz;

  mmio_uart_tx dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .data (data),
    .rw   (rw),
    .size (size),
    .tx   (tx),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        iso;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_status(int cnt, bit ovf, bit busy);
    return (32'(cnt) << 4) | {28'd0, ovf, busy, cnt == 0, cnt == 8};
  endfunction

  task automatic bus_idle();
    addr = 32'h0; rw = 1'b0; size = BYTE; drv_en = 1'b0; drv_val = 32'h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz);
    @(negedge clk);
    addr = a; rw = 1'b1; size = sz; drv_en = 1'b1; drv_val = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] sz,
                          input logic iso, output logic [31:0] v);
    @(negedge clk);
    addr = a; rw = 1'b0; size = sz; drv_en = iso; drv_val = ISO_PAT;
    #1 v = data;
    @(posedge clk); #1;
    bus_idle();
  endtask

  // UART receiver: find start bit, sample each bit in its middle
  task automatic rx_frame(input int dv, output logic [7:0] b, output logic ok);
    int w;
    logic [9:0] fr;
    ok = 1'b0; b = 8'h0; w = 0;
    while (tx !== 1'b0 && w < 5000) begin cyc(1); w++; end
    if (tx !== 1'b0) return;
    cyc(dv / 2);
    fr[0] = tx;
    for (int j = 1; j < 10; j++) begin
      cyc(dv + 1);
      fr[j] = tx;
    end
    b = fr[8:1];
    ok = (fr[0] == 1'b0) && (fr[9] == 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (irq !== 1'b1 && w < 20000) begin cyc(1); w++; end
    check(name, {31'd0, irq}, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [9:0]  fr;
    logic [15:0] trace, exp_tr;
    logic [7:0]  got;
    logic        ok;
    logic [7:0]  q[$];
    int          errs, dv, n, lows;

    bus_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd1);
    bus_read(A_ST, WORD, 1'b0, v);
    check("rst_status", v, 32'h2);
    bus_read(A_DIV, WORD, 1'b0, v);
    check("rst_div", v, 32'h3);

    tbl.push_back('{1'b0, A_ST,            WORD, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b0, A_DIV,           WORD, 32'h0,        1'b0, 32'h3});
    tbl.push_back('{1'b0, A_TX,            WORD, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'hC,    WORD, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, BASE + 32'h6,    HALF, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, A_DIV,           HALF, 32'h1234,     1'b0, 32'h0});
    tbl.push_back('{1'b0, A_DIV,           WORD, 32'h0,        1'b0, 32'h3});
    tbl.push_back('{1'b1, A_DIV,           BYTE, 32'h55,       1'b0, 32'h0});
    tbl.push_back('{1'b0, A_DIV,           WORD, 32'h0,        1'b0, 32'h3});
    tbl.push_back('{1'b1, A_DIV,           WORD, 32'hABCD0009, 1'b0, 32'h0});
    tbl.push_back('{1'b0, A_DIV,           WORD, 32'h0,        1'b0, 32'h9});
    tbl.push_back('{1'b0, A_DIV,           RSVD, 32'h0,        1'b1, ISO_PAT});
    tbl.push_back('{1'b0, 32'h00001008,    WORD, 32'h0,        1'b1, ISO_PAT});
    tbl.push_back('{1'b0, 32'h00001000,    WORD, 32'h0,        1'b1, ISO_PAT});
    tbl.push_back('{1'b1, BASE + 32'h10,   WORD, 32'h41,       1'b0, 32'h0});
    tbl.push_back('{1'b0, A_ST,            WORD, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b1, A_TX,            RSVD, 32'h42,       1'b0, 32'h0});
    tbl.push_back('{1'b0, A_ST,            WORD, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b1, BASE + 32'hC,    WORD, 32'h43,       1'b0, 32'h0});
    tbl.push_back('{1'b0, A_ST,            WORD, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b1, A_ST,            BYTE, 32'hFF,       1'b0, 32'h0});
    tbl.push_back('{1'b0, A_ST,            WORD, 32'h0,        1'b0, 32'h2});
    tbl.push_back('{1'b1, A_DIV,           WORD, 32'h3,        1'b0, 32'h0});
    tbl.push_back('{1'b0, A_DIV,           WORD, 32'h0,        1'b0, 32'h3});
    foreach (tbl[i]) begin
      if (tbl[i].rw) bus_write(tbl[i].a, tbl[i].d, tbl[i].sz);
      else begin
        bus_read(tbl[i].a, tbl[i].sz, tbl[i].iso, v);
        check($sformatf("vec%0d", i), v, tbl[i].exp);
      end
    end

    // single 0x55 frame at div=3: 10 bit times of 4 clocks
    fr = {1'b1, 8'h55, 1'b0};
    errs = 0;
    bus_write(A_TX, 32'h55, BYTE);
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) begin
        bus_read(A_ST, WORD, 1'b0, v);
        check("f55_status", v, exp_status(0, 1'b0, 1'b1));
      end else cyc(1);
      if (tx !== fr[(k - 1) / 4]) errs++;
      if (irq !== 1'b0) errs++;
    end
    check("f55_tx", 32'(errs), 32'd0);
    cyc(1);
    check("f55_irq_after", {31'd0, irq}, 32'd1);
    check("f55_tx_after", {31'd0, tx}, 32'd1);

    // divisor drops to 0 during the start bit
    bus_write(A_TX, 32'h0F, BYTE);
    exp_tr = 16'hFFFF;
    for (int k = 0; k < 4; k++) exp_tr[k] = 1'b0;
    for (int k = 0; k < 8; k++) exp_tr[4 + k] = (8'h0F >> k) & 8'h1;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) bus_write(A_DIV, 32'h0, WORD);
      else cyc(1);
      trace[k] = tx;
    end
    check("divchg_tx", {16'd0, trace}, {16'd0, exp_tr});
    bus_read(A_DIV, WORD, 1'b0, v);
    check("divchg_div", v, 32'h0);
    wait_idle("divchg_idle");

    // randomized bursts decoded by the receiver model
    for (int r = 0; r < 6; r++) begin
      dv = $urandom_range(0, 4);
      n = $urandom_range(1, 8);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      bus_write(A_DIV, 32'(dv), WORD);
      fork
        begin
          foreach (q[i]) begin
            v = $urandom;
            v[7:0] = q[i];
            bus_write(A_TX, v, 2'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
        end
        begin
          for (int i = 0; i < n; i++) begin
            rx_frame(dv, got, ok);
            check($sformatf("rnd%0d_frame%0d_ok", r, i), {31'd0, ok}, 32'd1);
            check($sformatf("rnd%0d_byte%0d", r, i), {24'd0, got}, {24'd0, q[i]});
          end
        end
      join
      wait_idle("rnd_idle");
      bus_read(A_ST, WORD, 1'b0, v);
      check("rnd_status", v, exp_status(0, 1'b0, 1'b0));
    end

    // overflow: 9 accepted, the tenth dropped and flagged
    bus_write(A_DIV, 32'd100, WORD);
    fork
      begin
        for (int i = 1; i <= 9; i++) bus_write(A_TX, 32'(i), BYTE);
        bus_read(A_ST, WORD, 1'b0, v);
        check("ovf_full", v, exp_status(8, 1'b0, 1'b1));
        bus_write(A_TX, 32'h0A, BYTE);
        bus_read(A_ST, WORD, 1'b0, v);
        check("ovf_set", v, exp_status(8, 1'b1, 1'b1));
        bus_write(A_ST, 32'h8, WORD);
        bus_read(A_ST, WORD, 1'b0, v);
        check("ovf_clear", v, exp_status(8, 1'b0, 1'b1));
      end
      begin
        for (int i = 1; i <= 9; i++) begin
          rx_frame(100, got, ok);
          check($sformatf("ovf_frame%0d_ok", i), {31'd0, ok}, 32'd1);
          check($sformatf("ovf_byte%0d", i), {24'd0, got}, 32'(i));
        end
      end
    join
    lows = 0;
    for (int k = 0; k < 2500; k++) begin
      cyc(1);
      if (tx !== 1'b1) lows++;
    end
    check("ovf_no_tenth", 32'(lows), 32'd0);
    bus_read(A_ST, WORD, 1'b0, v);
    check("ovf_end_status", v, exp_status(0, 1'b0, 1'b0));

    // async reset during data bit 3 of 0xA5 at div=7
    bus_write(A_DIV, 32'd7, WORD);
    bus_write(A_TX, 32'hA5, BYTE);
    for (int i = 2; i <= 10; i++) bus_write(A_TX, 32'(i), BYTE);
    bus_read(A_ST, WORD, 1'b0, v);
    check("ar_pre_status", v, exp_status(8, 1'b1, 1'b1));
    cyc(26);
    check("ar_bit3", {31'd0, tx}, 32'd0);
    #3 rst = 1'b0;
    #1;
    check("ar_tx_now", {31'd0, tx}, 32'd1);
    check("ar_irq_now", {31'd0, irq}, 32'd1);
    bus_read(A_ST, WORD, 1'b0, v);
    check("ar_status_in_rst", v, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    bus_read(A_ST, WORD, 1'b0, v);
    check("ar_status", v, exp_status(0, 1'b0, 1'b0));
    bus_read(A_DIV, WORD, 1'b0, v);
    check("ar_div", v, 32'h3);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1);
      if (tx !== 1'b1) lows++;
    end
    check("ar_line_idle", 32'(lows), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped responder on the RiscVCore memory bus: addr/data/rw/size, the same interface MemoryController answers.
- Decodes a small register window at BASE_ADDR.
- Buffers CPU byte stores in a TX FIFO and serialises them onto a UART line (8N1, LSB first).
- Sits beside MemoryController on the shared bus. It drives data only when selected for a read, otherwise high-Z.

Parameters:
- BASE_ADDR, 32'hFFFF0000: window base; window is 16 bytes, addr[3:0] selects the register.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd3: reset value of DIVISOR (clocks per bit minus 1).

Ports:
- clk  in  1  bus/core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  bus address.
- data  inout  32  bus data; driven only on a selected read.
- rw  in  1  1 = write (store), 0 = read (load).
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (access ignored).
- tx  out  1  serial output, idle high.
- irq  out  1  high when FIFO is empty and the serialiser is idle.

Behaviour:
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]) && size != 3. One access per rising clk edge while sel; the initiator holds each access for exactly one cycle.
- Read path is combinational: data = sel && !rw ? rdata : 32'bz. Reads have no side effects.
- Register map (offset = addr[3:0]):
  - 0x0 TXDATA. Write of any size pushes data[7:0]. Reads return 0.
  - 0x4 STATUS. Read returns {count[27:4] zero-extended, ovf[3], busy[2], empty[1], full[0]}. A word write with data[3]=1 clears ovf. Other writes are ignored.
  - 0x8 DIVISOR. Word write loads data[15:0]. Read returns {16'b0, div}. Non-word writes are ignored.
  - 0xC and unaligned offsets. Reads return 0; writes are ignored.
- FIFO push:
  - A push when full drops the byte and sets ovf (sticky).
  - A push in the same cycle the serialiser pops is accepted, even if full before the pop.
- Serialiser FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. If FIFO is non-empty, pop into shift register, load baud counter = div, go to START.
  - Every state holds for div+1 clocks. The baud counter decrements to 0, then reloads from the current div.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right each bit time; bit counter 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for one bit time. Then IDLE; the next byte starts the cycle after (back-to-back frames, no extra idle).
- busy = (state != IDLE). empty and full reflect the FIFO after this cycle's edge; count is in the range 0..FIFO_DEPTH.
- A DIVISOR write mid-frame takes effect at the next bit boundary. div=0 gives 1 clock per bit.
- Reset, async, mid-frame: state=IDLE, tx=1, FIFO empty, ovf=0, div=DEFAULT_DIV, irq=1, data=z. The in-flight byte is lost.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives the even parity of the frame byte (XOR of 8 bits) for one bit time. STATUS bit 4 reads 1 (parity present).
- When undefined: no PARITY state, STATUS[4]=0, frame is 10 bit times.

Decomposition:
- Package uart_pkg:
  - register offsets (TXDATA=0x0, STATUS=0x4, DIVISOR=0x8)
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - STATUS bit indices
  - FSM state enum
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count. Parameter DEPTH. Pointers one bit wider than the index for the full/empty distinction.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> tx=1, irq=1. Read 0xFFFF0004 -> 0x00000002. Read 0xFFFF0008 -> 0x00000003.
- Single frame, div=3: byte store 0x55 to 0xFFFF0000 -> tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks. Total 40 clocks; busy=1 throughout; irq=1 after.
- Overflow: div=100, store 9 bytes 0x01..0x09 back-to-back (FIFO_DEPTH=8, first popped immediately) -> all 9 accepted, STATUS full=1. Tenth store 0x0A sets ovf (STATUS bit3=1). Word write 0x8 to STATUS clears ovf; 0x0A is never transmitted.
- Divisor change: write DIVISOR=0 mid-frame at div=3 -> current bit finishes at 4 clocks, subsequent bits last 1 clock. Reading 0x8 returns 0.
- Bus isolation: read at 0x00001000 and write at 0xFFFF0010 -> data stays z and no FIFO change. Read 0xFFFF000C -> 0. Half write to DIVISOR -> div unchanged.
- Async reset mid-frame: assert rst during DATA bit 3 -> tx=1 immediately (no clock edge needed), FIFO empty, ovf=0, div=3.
